// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the bus_interconnect block.
// Holds the transaction state enum, bus widths and the default error read data.
package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_ERROR  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bus_interconnect_if.sv
// bus_interconnect_if: picorv32 native memory bus on the CPU side plus the
// per-slave select/ready/read-data fan-out on the slave side.
//
// Handshake: the CPU raises mem_valid with mem_addr/mem_wstrb stable and holds
// them until mem_ready is seen high on a rising clk edge; mem_ready is a
// single-cycle completion pulse and mem_rdata is only meaningful (and is
// otherwise 0) while mem_ready is high. A slave completes its access by
// raising its slv_ready bit while its slv_sel bit is high; slv_ready bits of
// unselected slaves carry no meaning.
interface bus_interconnect_if #(
  parameter int NSLAVES = 8
);
  import bus_pkg::*;

  logic                        mem_valid;
  logic [ADDR_W-1:0]           mem_addr;
  logic [3:0]                  mem_wstrb;
  logic                        mem_ready;
  logic [DATA_W-1:0]           mem_rdata;
  logic [NSLAVES-1:0]          slv_sel;
  logic [NSLAVES-1:0]          slv_ready;
  logic [NSLAVES*DATA_W-1:0]   slv_rdata;

  // CPU plus slaves: everything the interconnect does not drive.
  modport master (
    output mem_valid, mem_addr, mem_wstrb, slv_ready, slv_rdata,
    input  mem_ready, mem_rdata, slv_sel
  );

  // The interconnect itself.
  modport slave (
    input  mem_valid, mem_addr, mem_wstrb, slv_ready, slv_rdata,
    output mem_ready, mem_rdata, slv_sel
  );

endinterface

// File: rtl/bus_decoder.sv
// bus_decoder: combinational base/mask region match of an address.
// Slave i matches when (addr & mask_i) == base_i; the lowest matching
// index wins when regions overlap.
module bus_decoder
  import bus_pkg::*;
#(
  parameter int                    NSLAVES  = 8,
  parameter int                    IDXW     = 3,
  parameter logic [NSLAVES*32-1:0] SLV_BASE = '0,
  parameter logic [NSLAVES*32-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDXW-1:0]   index
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
        hit   = 1'b1;
        index = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// bus_interconnect: picorv32 memory bus to NSLAVES memory-mapped slaves.
// Registered IDLE/ACTIVE/ERROR/DONE transaction FSM, priority region decode,
// read-data mux and an error response for unmapped addresses.
// Optional feature macro: BUS_TIMEOUT_EN builds a watchdog that turns an
// ACTIVE access lasting TIMEOUT_CYCLES cycles into an error response.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int                    NSLAVES        = 8,
  parameter logic [NSLAVES*32-1:0] SLV_BASE       = '0,
  parameter logic [NSLAVES*32-1:0] SLV_MASK       = '0,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0]     ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  bus_interconnect_if.slave  bus,
  output logic               err_irq,
  output logic [ADDR_W-1:0]  err_addr,
  output logic               err_write,
  output state_t             state
);

  localparam int IDXW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [IDXW-1:0]   idx_q;
  logic              dec_hit;
  logic [IDXW-1:0]   dec_idx;
  logic              sel_ready;
  logic              tmo_hit;
  logic [NSLAVES-1:0] one_hot;

  assign state = state_q;

  bus_decoder #(
    .NSLAVES  (NSLAVES),
    .IDXW     (IDXW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decoder (
    .addr  (bus.mem_addr),
    .hit   (dec_hit),
    .index (dec_idx)
  );

  // Ready of the latched slave only; all other slave ready bits are ignored.
  assign sel_ready = bus.slv_ready[idx_q];

`ifdef BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts ACTIVE cycles without slave ready, zero outside ACTIVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state_q != S_ACTIVE) begin
      tmo_cnt <= '0;
    end else if (!sel_ready) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // One-hot decode of the latched slave index.
  always_comb begin
    one_hot        = '0;
    one_hot[idx_q] = 1'b1;
  end

  // State, latched slave index and error capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      err_addr  <= '0;
      err_write <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.mem_valid && dec_hit) begin
        idx_q <= dec_idx;
      end
      if (state_d == S_ERROR && state_q != S_ERROR) begin
        err_addr  <= bus.mem_addr;
        err_write <= |bus.mem_wstrb;
      end
    end
  end

  // Next state plus select, ready, read mux and error pulse.
  always_comb begin
    state_d       = state_q;
    bus.slv_sel   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    err_irq       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_valid) begin
          state_d = dec_hit ? S_ACTIVE : S_ERROR;
        end
      end
      S_ACTIVE: begin
        bus.slv_sel = one_hot;
        if (!bus.mem_valid) begin
          // CPU abandoned the request: finish quietly.
          state_d = S_DONE;
        end else if (sel_ready) begin
          // Slave ready takes priority over a simultaneous timeout.
          bus.mem_ready = 1'b1;
          bus.mem_rdata = bus.slv_rdata[int'(idx_q)*DATA_W +: DATA_W];
          state_d       = S_DONE;
        end else if (tmo_hit) begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = ERR_RDATA;
        err_irq       = 1'b1;
        state_d       = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
